// File: rtl/pla_sweep_pkg.sv
// Shared types and MISR helper for the PLA sweep controller.
// Sweep FSM states, default MISR constants, width-generic MISR step.
package pla_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

  localparam logic [31:0] DEF_SIG_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] DEF_SIG_SEED = 32'hFFFF_FFFF;

  // Works on up to 64 bits; bits at and above 'width' are forced to zero.
  function automatic logic [63:0] misr_next(input logic [63:0] sig,
                                            input logic [63:0] poly,
                                            input int          width,
                                            input logic        bit_in);
    logic [63:0] mask;
    logic [63:0] fb;
    mask = (64'd1 << width) - 64'd1;
    fb   = ((sig & (64'd1 << (width - 1))) != 64'd0) ? poly : 64'd0;
    return (((sig << 1) ^ fb) & mask) ^ {63'd0, bit_in};
  endfunction

endpackage

// File: rtl/pla_sweep_fifo2.sv
// 2-entry first-word-fall-through buffer; head visible the cycle after push.
// Push accepted when not full, or when full and popping in the same cycle.
module pla_sweep_fifo2 #(
  parameter int N_IN = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic [N_IN-1:0] push_dat_i,
  input  logic            pop_i,
  output logic [N_IN-1:0] pop_dat_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [N_IN-1:0] head_q, head_d;
  logic [N_IN-1:0] tail_q, tail_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            do_pop, do_push;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    do_pop  = pop_i & (cnt_q != 2'd0);
    do_push = push_i & ((cnt_q != 2'd2) | do_pop);
    case (cnt_q)
      2'd0: begin
        if (do_push) begin
          head_d = push_dat_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (do_push && do_pop) begin
          head_d = push_dat_i;
        end else if (do_pop) begin
          cnt_d = 2'd0;
        end else if (do_push) begin
          tail_d = push_dat_i;
          cnt_d  = 2'd2;
        end
      end
      default: begin
        if (do_pop) begin
          head_d = tail_q;
          if (do_push) tail_d = push_dat_i;
          else         cnt_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pop_dat_o = head_q;
  assign full_o    = (cnt_q == 2'd2);
  assign empty_o   = (cnt_q == 2'd0);

endmodule

// File: rtl/pla_sweep_ctrl.sv
// Walks an inclusive vector range into a PLA netlist, one vector per cycle,
// streaming ON-set minterms out; stalls only when y=1 meets a full, unpopped FIFO.
module pla_sweep_ctrl
  import pla_sweep_pkg::*;
#(
  parameter int              N_IN     = 23,
  parameter int              CNT_W    = 24,
  parameter int              SIG_W    = 32,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY),
  parameter logic [SIG_W-1:0] SIG_SEED = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_IN-1:0]  lo,
  input  logic [N_IN-1:0]  hi,
  output logic [N_IN-1:0]  x_out,
  input  logic             y_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N_IN-1:0]  m_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] on_count,
  output logic [SIG_W-1:0] signature
);

  sweep_state_e     state_q, state_d;
  logic [N_IN-1:0]  x_q, x_d;
  logic [N_IN-1:0]  hi_q, hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             err_q, err_d;

  logic fifo_push, fifo_pop, fifo_full, fifo_empty, stall;

  assign m_valid  = ~fifo_empty;
  assign fifo_pop = m_valid & m_ready;
  assign stall    = y_in & fifo_full & ~fifo_pop;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    err_d     = err_q;
    fifo_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (hi >= lo) begin
            hi_d    = hi;
            x_d     = lo;
            sig_d   = SIG_SEED;
            err_d   = 1'b0;
            state_d = ST_RUN;
          end else begin
            sig_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (!stall) begin
          cnt_d     = cnt_q + CNT_W'(y_in);
          sig_d     = SIG_W'(misr_next(64'(sig_q), 64'(SIG_POLY), SIG_W, y_in));
          fifo_push = y_in;
          // Stop on hi rather than incrementing, so the all-ones vector never wraps.
          if (x_q == hi_q) state_d = ST_DRAIN;
          else             x_d     = x_q + N_IN'(1);
        end
      end
      ST_DRAIN: begin
        // Leave as the last entry is being popped so done lands at T0+K+2.
        if (fifo_empty || (!fifo_full && fifo_pop)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      err_q   <= err_d;
    end
  end

  pla_sweep_fifo2 #(.N_IN(N_IN)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fifo_push),
    .push_dat_i (x_q),
    .pop_i      (fifo_pop),
    .pop_dat_o  (m_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign x_out     = x_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign on_count  = cnt_q;
  assign signature = sig_q;

endmodule
